// File: rtl/wdt_pkg.sv
// Shared types and elaboration-time parameter checks for multi_channel_watchdog.
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WARN,
        TRIP
    } wdt_state_e;

    function automatic bit wdt_params_ok(
        input int unsigned num_ch,
        input int unsigned cnt_w,
        input int unsigned min_c,
        input int unsigned warn_c,
        input int unsigned timeout_c,
        input int unsigned pulse
    );
        longint unsigned cnt_max;
        if (cnt_w == 0) return 1'b0;
        cnt_max = (cnt_w >= 63) ? '1 : ((64'd1 << cnt_w) - 64'd1);
        return (num_ch >= 1) && (num_ch <= 16) &&
               (min_c > 0) && (min_c < warn_c) && (warn_c < timeout_c) &&
               (longint'(timeout_c) <= cnt_max) && (pulse >= 1);
    endfunction

endpackage

// File: rtl/multi_channel_watchdog_if.sv
// Heartbeat/control and status bundle between the supervised plane and the watchdog.
interface multi_channel_watchdog_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] heartbeat;
    logic [NUM_CH-1:0] clear;
    logic [NUM_CH-1:0] warning;
    logic [NUM_CH-1:0] triggered;
    logic [NUM_CH-1:0] window_fault;
    logic              force_reset;

    modport master (
        output enable, heartbeat, clear,
        input  warning, triggered, window_fault, force_reset
    );

    modport slave (
        input  enable, heartbeat, clear,
        output warning, triggered, window_fault, force_reset
    );
endinterface

// File: rtl/wdt_channel.sv
// One supervised channel: IDLE/RUN/WARN/TRIP FSM, kick counter and sticky flags.
// WDT_WINDOW_EN adds the early-heartbeat (window) check.
module wdt_channel
    import wdt_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned WARN_CYCLES    = 48,
    parameter int unsigned TIMEOUT_CYCLES = 64
`ifdef WDT_WINDOW_EN
    ,
    parameter int unsigned MIN_CYCLES     = 4
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic heartbeat,
    input  logic clear,
    output logic warning,
    output logic triggered,
    output logic window_fault,
    output logic trip_entry
);

    localparam logic [CNT_W-1:0] WARN_V    = CNT_W'(WARN_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);

    wdt_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             early;

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        early   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) state_n = RUN;
            end
            RUN, WARN: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (heartbeat) begin
                    state_n = RUN;
                    cnt_n   = '0;
`ifdef WDT_WINDOW_EN
                    if (state == RUN && cnt < CNT_W'(MIN_CYCLES)) begin
                        state_n = TRIP;
                        early   = 1'b1;
                    end
`endif
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TIMEOUT_V)   state_n = TRIP;
                    else if (cnt_inc == WARN_V) state_n = WARN;
                end
            end
            TRIP: begin
                if (clear) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign trip_entry = (state_n == TRIP) && (state != TRIP);
    assign warning    = (state == WARN);
    assign triggered  = (state == TRIP);

`ifdef WDT_WINDOW_EN
    logic wf;
    // A new early fault outranks a clear arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst)        wf <= 1'b0;
        else if (early) wf <= 1'b1;
        else if (clear) wf <= 1'b0;
    end
    assign window_fault = wf;
`else
    assign window_fault = 1'b0;
    logic unused_early;
    assign unused_early = early;
`endif

endmodule

// File: rtl/multi_channel_watchdog.sv
// NUM_CH-channel heartbeat watchdog with one shared, retriggerable force_reset pulse.
// Define WDT_WINDOW_EN to trip channels on heartbeats earlier than MIN_CYCLES.
module multi_channel_watchdog
    import wdt_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned WARN_CYCLES    = 48,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned RESET_PULSE    = 16,
    parameter int unsigned MIN_CYCLES     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_channel_watchdog_if.slave  wd
);

    localparam int unsigned PW      = $clog2(RESET_PULSE + 1);
    localparam logic [PW-1:0] PULSE_V = PW'(RESET_PULSE);

    if (!wdt_params_ok(NUM_CH, CNT_W, MIN_CYCLES, WARN_CYCLES, TIMEOUT_CYCLES, RESET_PULSE)) begin : g_bad_params
        $error("multi_channel_watchdog: illegal parameter combination");
    end

    logic [NUM_CH-1:0] trip_vec;
    logic [PW-1:0]     pcnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        wdt_channel #(
            .CNT_W          (CNT_W),
            .WARN_CYCLES    (WARN_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`ifdef WDT_WINDOW_EN
            ,
            .MIN_CYCLES     (MIN_CYCLES)
`endif
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .enable       (wd.enable[g]),
            .heartbeat    (wd.heartbeat[g]),
            .clear        (wd.clear[g]),
            .warning      (wd.warning[g]),
            .triggered    (wd.triggered[g]),
            .window_fault (wd.window_fault[g]),
            .trip_entry   (trip_vec[g])
        );
    end

    // Any trip entry, even mid-pulse, restarts the full pulse length.
    always_ff @(posedge clk) begin
        if (rst)              pcnt <= '0;
        else if (|trip_vec)   pcnt <= PULSE_V;
        else if (pcnt != '0)  pcnt <= pcnt - PW'(1);
    end

    assign wd.force_reset = (pcnt != '0);

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Randomized and directed bench for multi_channel_watchdog against an age-based reference model.
module tb_multi_channel_watchdog;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int WARN  = 48;
    localparam int TMO   = 64;
    localparam int PULSE = 16;
    localparam int MINC  = 4;
`ifdef WDT_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_channel_watchdog_if #(.NUM_CH(NUM_CH)) wd ();

    multi_channel_watchdog #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .WARN_CYCLES    (WARN),
        .TIMEOUT_CYCLES (TMO),
        .RESET_PULSE    (PULSE),
        .MIN_CYCLES     (MINC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wd  (wd)
    );

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    // Model: each channel is idle, supervising with an age since last kick, or tripped.
    bit m_run  [NUM_CH];
    int m_age  [NUM_CH];
    bit m_trip [NUM_CH];
    bit m_wf   [NUM_CH];
    int m_pulse = 0;

    always @(posedge clk) begin : model
        bit any_new;
        bit nf;
        any_new = 1'b0;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_run[c] = 0; m_age[c] = 0; m_trip[c] = 0; m_wf[c] = 0;
            end
            m_pulse = 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                nf = 1'b0;
                if (m_trip[c]) begin
                    if (wd.clear[c]) begin
                        m_trip[c] = 0; m_run[c] = 0; m_age[c] = 0;
                    end
                end else if (m_run[c]) begin
                    if (!wd.enable[c]) begin
                        m_run[c] = 0; m_age[c] = 0;
                    end else if (wd.heartbeat[c]) begin
                        if (WIN && m_age[c] < MINC) begin
                            m_trip[c] = 1; nf = 1'b1; any_new = 1'b1;
                        end
                        m_age[c] = 0;
                    end else begin
                        m_age[c]++;
                        if (m_age[c] == TMO) begin
                            m_trip[c] = 1; any_new = 1'b1;
                        end
                    end
                end else if (wd.enable[c]) begin
                    m_run[c] = 1; m_age[c] = 0;
                end
                if (nf) m_wf[c] = 1;
                else if (wd.clear[c]) m_wf[c] = 0;
            end
            if (any_new) m_pulse = PULSE;
            else if (m_pulse > 0) m_pulse--;
        end
    end

    task automatic check(input string name, input int ch, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s ch=%0d t=%0t actual=%0d required=%0d", name, ch, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int c = 0; c < NUM_CH; c++) begin
                check("warning", c, int'(wd.warning[c]),
                      int'(m_run[c] && !m_trip[c] && m_age[c] >= WARN));
                check("triggered", c, int'(wd.triggered[c]), int'(m_trip[c]));
                check("window_fault", c, int'(wd.window_fault[c]), int'(m_wf[c]));
            end
            check("force_reset", -1, int'(wd.force_reset), int'(m_pulse > 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wd.enable = '0; wd.heartbeat = '0; wd.clear = '0;
        tick();
        rst = 1'b0;
    endtask

    int fr_cnt, rises, seen;
    bit prev_fr;

    initial begin
        wd.enable = '0; wd.heartbeat = '0; wd.clear = '0;
        do_reset();
        checking = 1'b1;
        check("reset_outputs", -1,
              int'({wd.warning, wd.triggered, wd.window_fault, wd.force_reset}), 0);

        // Free-running timeout on ch0.
        wd.enable[0] = 1'b1;
        tick();
        for (int k = 1; k <= 81; k++) begin
            tick();
            if (k == 47) check("lit_warn_before", 0, int'(wd.warning[0]), 0);
            if (k == 48) check("lit_warn_at48", 0, int'(wd.warning[0]), 1);
            if (k == 63) check("lit_trig_before", 0, int'(wd.triggered[0]), 0);
            if (k == 64) check("lit_trig_fr_at64", 0, int'({wd.triggered[0], wd.force_reset}), 3);
            if (k == 79) check("lit_fr_last", -1, int'(wd.force_reset), 1);
            if (k == 80) check("lit_fr_end", -1, int'(wd.force_reset), 0);
            if (k == 81) check("lit_trig_sticky", 0, int'(wd.triggered[0]), 1);
        end

        // Regular kicks every 40 cycles never warn.
        do_reset();
        wd.enable[0] = 1'b1;
        tick();
        seen = 0;
        for (int i = 0; i < 1000; i++) begin
            wd.heartbeat[0] = (i % 40 == 39);
            tick();
            if (wd.warning[0] || wd.triggered[0] || wd.force_reset) seen++;
        end
        wd.heartbeat[0] = 1'b0;
        check("lit_kick40_quiet", 0, seen, 0);

        // Staggered trips on ch1/ch2 merge into one 26-cycle pulse.
        do_reset();
        wd.enable[1] = 1'b1;
        tick();
        repeat (9) tick();
        wd.enable[2] = 1'b1;
        tick();
        fr_cnt = 0; rises = 0; prev_fr = 1'b0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (wd.force_reset) fr_cnt++;
            if (wd.force_reset && !prev_fr) rises++;
            prev_fr = wd.force_reset;
        end
        check("lit_merged_len", -1, fr_cnt, 26);
        check("lit_merged_rises", -1, rises, 1);
        wd.clear[1] = 1'b1;
        tick();
        wd.clear[1] = 1'b0;
        check("lit_clear_drops", 1, int'(wd.triggered[1]), 0);
        tick();

        // Heartbeat on the timeout edge wins; clear+heartbeat in TRIP goes idle.
        do_reset();
        wd.enable[0] = 1'b1;
        tick();
        repeat (63) tick();
        wd.heartbeat[0] = 1'b1;
        tick();
        wd.heartbeat[0] = 1'b0;
        check("lit_late_kick", 0, int'({wd.triggered[0], wd.force_reset}), 0);
        repeat (64) tick();
        check("lit_trip_after_kick", 0, int'(wd.triggered[0]), 1);
        wd.clear[0] = 1'b1; wd.heartbeat[0] = 1'b1;
        tick();
        wd.clear[0] = 1'b0; wd.heartbeat[0] = 1'b0;
        check("lit_clear_hb", 0, int'(wd.triggered[0]), 0);
        repeat (50) tick();
        check("lit_rearmed_warn", 0, int'(wd.warning[0]), 1);

        // Reset mid-pulse, then disable mid-WARN.
        do_reset();
        wd.enable[0] = 1'b1;
        tick();
        repeat (64) tick();
        repeat (5) tick();
        check("lit_pulse_active", -1, int'(wd.force_reset), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("lit_rst_mid_pulse", -1,
              int'({wd.warning, wd.triggered, wd.window_fault, wd.force_reset}), 0);
        tick();
        repeat (55) tick();
        check("lit_in_warn", 0, int'(wd.warning[0]), 1);
        wd.enable[0] = 1'b0;
        tick();
        check("lit_disable_warn", 0, int'(wd.warning[0]), 0);

        // Early heartbeat on ch3.
        do_reset();
        wd.enable[3] = 1'b1;
        tick();
        repeat (10) tick();
        wd.heartbeat[3] = 1'b1;
        tick();
        wd.heartbeat[3] = 1'b0;
        tick();
        wd.heartbeat[3] = 1'b1;
        tick();
        wd.heartbeat[3] = 1'b0;
        check("lit_early_trig", 3, int'(wd.triggered[3]), int'(WIN));
        check("lit_early_wf", 3, int'(wd.window_fault[3]), int'(WIN));
        fr_cnt = int'(wd.force_reset);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (wd.force_reset) fr_cnt++;
        end
        check("lit_early_pulse", -1, fr_cnt, WIN ? 16 : 0);

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 99) == 0) wd.enable[c] = ~wd.enable[c];
                else if (i == 0) wd.enable[c] = 1'b1;
                wd.heartbeat[c] = ($urandom_range(0, 44) == 0);
                wd.clear[c]     = ($urandom_range(0, 59) == 0);
            end
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0;
        wd.heartbeat = '0; wd.clear = '0;
        tick();

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
